// File: rtl/andor3_pkg.sv
// Shared types and constants for the andor3 gate checkers.
package andor3_pkg;

    // Checker sequencing states.
    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } chk_state_t;

    // Exhaustive sweep over the three gate inputs.
    localparam int         NUM_VEC  = 8;
    localparam logic [2:0] LAST_VEC = 3'(NUM_VEC - 1);

endpackage

// File: rtl/andor3_ref_model.sv
// Combinational golden model of the andor3 gate: y is the 3-input AND, z the 3-input OR.
// vec[2]=a, vec[1]=b, vec[0]=c.
module andor3_ref_model (
    input  logic [2:0] vec,
    output logic       y_exp,
    output logic       z_exp
);

    assign y_exp = &vec;
    assign z_exp = |vec;

endmodule

// File: rtl/andor3_resp_checker.sv
// Self-test engine for the andor3 gate: sweeps all input vectors PASSES times, holds each
// vector SETTLE_CYCLES cycles, samples y/z, and reports pass, a saturating error count and
// the first failing vector.
module andor3_resp_checker
    import andor3_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    input  logic             y,
    input  logic             z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [2:0]       first_fail_vec
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

    chk_state_t      state_q, state_d;
    logic [2:0]      vec_q;
    logic [SW-1:0]   settle_cnt_q;
    logic [PW-1:0]   pass_cnt_q;
    logic            y_exp, z_exp;
    logic            mismatch;
    logic            settle_last;
    logic            run_last;
    logic            launch;

    andor3_ref_model u_ref (
        .vec   (vec_q),
        .y_exp (y_exp),
        .z_exp (z_exp)
    );

    assign mismatch    = ({y, z} != {y_exp, z_exp});
    assign settle_last = (settle_cnt_q == SW'(SETTLE_CYCLES - 1));
    assign run_last    = (vec_q == LAST_VEC) && (pass_cnt_q == PW'(PASSES - 1));
    assign launch      = start && ((state_q == IDLE) || (state_q == DONE));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = SETTLE;
            SETTLE:     if (settle_last) state_d = SAMPLE;
            SAMPLE:     state_d = run_last ? DONE : SETTLE;
            default:    state_d = IDLE;
        endcase
    end

    // Vector/settle/pass counters, saturating error counter and first-fail capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q            <= '0;
            settle_cnt_q     <= '0;
            pass_cnt_q       <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (launch) begin
            vec_q            <= '0;
            settle_cnt_q     <= '0;
            pass_cnt_q       <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (state_q == SETTLE) begin
            settle_cnt_q <= settle_last ? '0 : settle_cnt_q + SW'(1);
        end else if (state_q == SAMPLE) begin
            if (mismatch) begin
                if (err_count != {ERR_W{1'b1}}) begin
                    err_count <= err_count + ERR_W'(1);
                end
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_vec   <= vec_q;
                end
            end
            if (!run_last) begin
                vec_q <= vec_q + 3'd1;
                if (vec_q == LAST_VEC) begin
                    pass_cnt_q <= pass_cnt_q + PW'(1);
                end
            end
        end
    end

    // Stimulus is driven only while a vector is being applied; status decodes from state.
    assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign pass      = done && (err_count == '0);
    assign {a, b, c} = busy ? vec_q : 3'b000;

endmodule

// File: tb/tb_andor3_resp_checker.sv
// Bench for andor3_resp_checker: a defaults instance and a PASSES=3 instance, each driving
// an emulated andor3 gate with selectable faults.
module tb_andor3_resp_checker;

    localparam int SETTLE = 2;

    typedef struct {
        int mode;
        int sel;
        int err;
        bit ffv;
        int ffvec;
        bit pass;
        int cycles;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_0 = 1'b0, start_3 = 1'b0;
    logic        a_0, b_0, c_0, y_0, z_0, busy_0, done_0, pass_0, ffv_0;
    logic        a_3, b_3, c_3, y_3, z_3, busy_3, done_3, pass_3, ffv_3;
    logic [3:0]  err_0, err_3;
    logic [2:0]  ffvec_0, ffvec_3;
    int          fault_mode = 0;
    logic [15:0] fault_bits = '0;
    logic        sel = 1'b0;

    logic        s_done, s_busy, s_pass, s_ffv;
    logic [3:0]  s_err;
    logic [2:0]  s_ffvec, s_abc;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Emulated andor3 device with a selectable fault.
    function automatic logic [1:0] bench_dut(input logic [2:0] v, input int mode,
                                             input logic [15:0] bits);
        logic [1:0] r;
        r = {&v, |v};
        case (mode)
            1: r[0] = 1'b1;
            2: r[1] = 1'b0;
            3: r[1] = ~r[1];
            4: r = r ^ bits[int'(v)*2 +: 2];
            default: ;
        endcase
        return r;
    endfunction

    assign {y_0, z_0} = bench_dut({a_0, b_0, c_0}, fault_mode, fault_bits);
    assign {y_3, z_3} = bench_dut({a_3, b_3, c_3}, fault_mode, fault_bits);

    andor3_resp_checker u_dut_0 (
        .clk (clk), .rst (rst), .start (start_0),
        .a (a_0), .b (b_0), .c (c_0), .y (y_0), .z (z_0),
        .busy (busy_0), .done (done_0), .pass (pass_0), .err_count (err_0),
        .first_fail_valid (ffv_0), .first_fail_vec (ffvec_0)
    );

    andor3_resp_checker #(.SETTLE_CYCLES(2), .PASSES(3), .ERR_W(4)) u_dut_3 (
        .clk (clk), .rst (rst), .start (start_3),
        .a (a_3), .b (b_3), .c (c_3), .y (y_3), .z (z_3),
        .busy (busy_3), .done (done_3), .pass (pass_3), .err_count (err_3),
        .first_fail_valid (ffv_3), .first_fail_vec (ffvec_3)
    );

    // Route the selected instance onto the shared observation signals.
    always_comb begin
        if (sel) begin
            s_done = done_3; s_busy = busy_3; s_pass = pass_3; s_ffv = ffv_3;
            s_err  = err_3;  s_ffvec = ffvec_3; s_abc = {a_3, b_3, c_3};
        end else begin
            s_done = done_0; s_busy = busy_0; s_pass = pass_0; s_ffv = ffv_0;
            s_err  = err_0;  s_ffvec = ffvec_0; s_abc = {a_0, b_0, c_0};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural expectation: golden y is "all three ones", golden z is "any one".
    // Each failing vector counts once per pass; the count clips at 15.
    function automatic vec_t model(input int mode, input logic [15:0] bits, input int sel_i);
        vec_t e;
        int   nfail, passes;
        logic [1:0] got, gold;
        passes = (sel_i != 0) ? 3 : 1;
        nfail  = 0;
        e.mode = mode; e.sel = sel_i; e.ffv = 1'b0; e.ffvec = 0;
        for (int v = 0; v < 8; v++) begin
            got  = bench_dut(3'(v), mode, bits);
            gold = {1'(v == 7), 1'(v != 0)};
            if (got != gold) begin
                if (!e.ffv) e.ffvec = v;
                e.ffv = 1'b1;
                nfail++;
            end
        end
        e.err    = (nfail * passes > 15) ? 15 : nfail * passes;
        e.pass   = (nfail == 0);
        e.cycles = 1 + passes * 8 * (SETTLE + 1);
        return e;
    endfunction

    // Pulse start on the selected instance and wait (bounded) for done, tracking that the
    // applied vector follows the sweep order while busy.
    task automatic run(input int sel_i, output int cycles, output int seq_err);
        sel = (sel_i != 0);
        if (sel_i != 0) start_3 = 1'b1; else start_0 = 1'b1;
        cycles  = 0;
        seq_err = 0;
        do begin
            @(posedge clk);
            #1;
            start_0 = 1'b0;
            start_3 = 1'b0;
            cycles++;
            if (!s_done && (!s_busy || s_abc != 3'(((cycles - 1) / (SETTLE + 1)) % 8)))
                seq_err++;
        end while (!s_done && cycles < 300);
    endtask

    task automatic check_run(input string tag, input vec_t e);
        int cycles, seq_err;
        fault_mode = e.mode;
        run(e.sel, cycles, seq_err);
        check({tag, ".cycles"}, cycles, e.cycles);
        check({tag, ".seq"},    seq_err, 0);
        check({tag, ".done"},   s_done, 1);
        check({tag, ".busy"},   s_busy, 0);
        check({tag, ".abc"},    s_abc, 0);
        check({tag, ".pass"},   s_pass, e.pass);
        check({tag, ".err"},    s_err, e.err);
        check({tag, ".ffv"},    s_ffv, e.ffv);
        if (e.ffv) check({tag, ".ffvec"}, s_ffvec, e.ffvec);
    endtask

    initial begin
        vec_t tbl[5];
        vec_t e;
        int   cycles, seq_err;

        tbl[0] = '{mode: 0, sel: 0, err: 0,  ffv: 0, ffvec: 0, pass: 1, cycles: 25};
        tbl[1] = '{mode: 1, sel: 0, err: 1,  ffv: 1, ffvec: 0, pass: 0, cycles: 25};
        tbl[2] = '{mode: 2, sel: 0, err: 1,  ffv: 1, ffvec: 7, pass: 0, cycles: 25};
        tbl[3] = '{mode: 3, sel: 1, err: 15, ffv: 1, ffvec: 0, pass: 0, cycles: 73};
        tbl[4] = '{mode: 0, sel: 1, err: 0,  ffv: 0, ffvec: 0, pass: 1, cycles: 73};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst.outs0", {a_0, b_0, c_0, busy_0, done_0, pass_0, ffv_0, err_0, ffvec_0}, 0);
        check("rst.outs3", {a_3, b_3, c_3, busy_3, done_3, pass_3, ffv_3, err_3, ffvec_3}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle.done0", done_0, 0);

        // Directed table; entry 4 restarts the PASSES=3 instance from a failing DONE.
        for (int i = 0; i < 5; i++) check_run($sformatf("tbl%0d", i), tbl[i]);

        // Restart from DONE after a failing run: results clear on the start edge.
        fault_mode = 2;
        run(0, cycles, seq_err);
        check("restart.pre_err", err_0, 1);
        fault_mode = 0;
        start_0 = 1'b1;
        @(posedge clk);
        #1;
        start_0 = 1'b0;
        check("restart.err_clr", err_0, 0);
        check("restart.ffv_clr", ffv_0, 0);
        check("restart.busy", {busy_0, done_0}, 2'b10);
        cycles = 1;
        while (!done_0 && cycles < 300) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("restart.cycles", cycles, 25);
        check("restart.pass", pass_0, 1);

        // Start re-pulsed while busy, then rst at cycle 10 of the run.
        sel = 1'b0;
        start_0 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            start_0 = (k == 4);
        end
        check("midrun.busy", busy_0, 1);
        check("midrun.abc", {a_0, b_0, c_0}, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.outs", {a_0, b_0, c_0, busy_0, done_0, pass_0, ffv_0, err_0}, 0);
        rst = 1'b0;
        check_run("fresh", tbl[0]);

        // Randomized fault patterns against the behavioural model.
        for (int r = 0; r < 8; r++) begin
            fault_bits = 16'($urandom);
            e = model(4, fault_bits, int'($urandom_range(0, 1)));
            check_run($sformatf("rnd%0d", r), e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
